// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures the decoded instruction for EX, detects load-use hazards (bubble
// plus upstream stall), applies branch flush and external stall, and keeps
// a sticky halt flag that drains the pipe once a halt instruction reaches EX.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_alusrc,
   input  logic              id_memtoreg,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_branch,
   input  logic              id_halt,
   input  logic [1:0]        id_aluop,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              ext_stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_alusrc,
   output logic              ex_memtoreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_branch,
   output logic              ex_halt,
   output logic [1:0]        ex_aluop,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic              stall_id,
   output logic              halted
);

   logic haz_s;
   logic bubble_s;

   // Load-use hazard: a load in EX whose destination (not x0) is read by ID.
   // Both sources are compared even if the instruction uses only one.
   always_comb begin
      haz_s = 1'b0;
      if (ex_valid && ex_memread && (ex_rd != {REG_AW{1'b0}}) && id_valid &&
          ((id_rs1 == ex_rd) || (id_rs2 == ex_rd))) begin
         haz_s = 1'b1;
      end else begin
         haz_s = 1'b0;
      end
   end

   // Choose bubble vs. real load; an invalid ID slot always loads a clean bubble.
   always_comb begin
      bubble_s = 1'b0;
      if (flush || halted || haz_s || !id_valid) begin
         bubble_s = 1'b1;
      end else begin
         bubble_s = 1'b0;
      end
   end

   // Upstream hold; a flush redirects IF/ID so it cancels the hazard hold.
   always_comb begin
      stall_id = ext_stall | (haz_s & ~flush) | halted;
   end

   // Pipeline register and sticky halt flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_branch   <= 1'b0;
         ex_halt     <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_pc       <= {XLEN{1'b0}};
         ex_rd1      <= {XLEN{1'b0}};
         ex_rd2      <= {XLEN{1'b0}};
         ex_imm      <= {XLEN{1'b0}};
         ex_rs1      <= {REG_AW{1'b0}};
         ex_rs2      <= {REG_AW{1'b0}};
         ex_rd       <= {REG_AW{1'b0}};
         ex_funct3   <= 3'b000;
         ex_funct7   <= 7'b0000000;
         halted      <= 1'b0;
      end else if (ext_stall) begin
         // Downstream stall: every register keeps its value.
         halted <= halted;
      end else if (bubble_s) begin
         ex_valid    <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_branch   <= 1'b0;
         ex_halt     <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_pc       <= {XLEN{1'b0}};
         ex_rd1      <= {XLEN{1'b0}};
         ex_rd2      <= {XLEN{1'b0}};
         ex_imm      <= {XLEN{1'b0}};
         ex_rs1      <= {REG_AW{1'b0}};
         ex_rs2      <= {REG_AW{1'b0}};
         ex_rd       <= {REG_AW{1'b0}};
         ex_funct3   <= 3'b000;
         ex_funct7   <= 7'b0000000;
      end else begin
         ex_valid    <= 1'b1;
         ex_alusrc   <= id_alusrc;
         ex_memtoreg <= id_memtoreg;
         ex_regwrite <= id_regwrite;
         ex_memread  <= id_memread;
         ex_memwrite <= id_memwrite;
         ex_branch   <= id_branch;
         ex_halt     <= id_halt;
         ex_aluop    <= id_aluop;
         ex_pc       <= id_pc;
         ex_rd1      <= id_rd1;
         ex_rd2      <= id_rd2;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7   <= id_funct7;
         halted      <= halted | id_halt;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when the
// ID-side stimulus is driven and compared one edge later.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic        alusrc;
      logic        memtoreg;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        branch;
      logic        halt;
      logic [1:0]  aluop;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        halted;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ext_stall;
   logic flush;
   ent_t cur;

   logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
   logic        ex_memwrite, ex_branch, ex_halt;
   logic [1:0]  ex_aluop;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic        stall_id, halted;

   int checks   = 0;
   int failures = 0;
   ent_t sb_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(cur.valid), .id_alusrc(cur.alusrc), .id_memtoreg(cur.memtoreg),
      .id_regwrite(cur.regwrite), .id_memread(cur.memread), .id_memwrite(cur.memwrite),
      .id_branch(cur.branch), .id_halt(cur.halt), .id_aluop(cur.aluop),
      .id_pc(cur.pc), .id_rd1(cur.rd1), .id_rd2(cur.rd2), .id_imm(cur.imm),
      .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
      .id_funct3(cur.funct3), .id_funct7(cur.funct7),
      .ext_stall(ext_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_branch(ex_branch), .ex_halt(ex_halt), .ex_aluop(ex_aluop),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .stall_id(stall_id), .halted(halted)
   );

   function automatic ent_t get_obs();
      ent_t o;
      o.valid = ex_valid;       o.alusrc = ex_alusrc;     o.memtoreg = ex_memtoreg;
      o.regwrite = ex_regwrite; o.memread = ex_memread;   o.memwrite = ex_memwrite;
      o.branch = ex_branch;     o.halt = ex_halt;         o.aluop = ex_aluop;
      o.pc = ex_pc;             o.rd1 = ex_rd1;           o.rd2 = ex_rd2;
      o.imm = ex_imm;           o.rs1 = ex_rs1;           o.rs2 = ex_rs2;
      o.rd = ex_rd;             o.funct3 = ex_funct3;     o.funct7 = ex_funct7;
      o.halted = halted;
      return o;
   endfunction

   // kind: 0 = add (R-type), 1 = lw, 2 = halt
   function automatic ent_t mk(input int kind, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
      ent_t e = '0;
      e.valid = 1'b1;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.rd1 = 32'd5; e.rd2 = 32'd7;
      case (kind)
         0: begin e.regwrite = 1'b1; e.aluop = 2'b10; end
         1: begin
            e.alusrc = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.memread = 1'b1;
            e.aluop = 2'b00; e.imm = 32'd4; e.funct3 = 3'b010; e.rd1 = 32'h100;
         end
         default: begin e.halt = 1'b1; e.aluop = 2'b00; end
      endcase
      return e;
   endfunction

   function automatic ent_t as_load(input ent_t e, input logic h);
      ent_t r = e;
      r.halted = h;
      return r;
   endfunction

   function automatic ent_t bubble(input logic h);
      ent_t r = '0;
      r.halted = h;
      return r;
   endfunction

   task automatic check_ent(input string tag, input ent_t obs, input ent_t exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   // Advance one edge, then compare EX against the oldest queued expectation.
   task automatic tick(input string tag);
      ent_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb_q.size() != 0) else begin
         failures++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_ent(tag, get_obs(), e);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ent_t held;
      rst_n = 1'b0; ext_stall = 1'b0; flush = 1'b0; cur = '0;
      #12;
      check_ent("reset_state", get_obs(), '0);
      check_bit("reset_stall", stall_id, 1'b0);
      ext_stall = 1'b1; #1;
      check_bit("reset_stall_ext", stall_id, 1'b1);
      ext_stall = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // T1 pass-through add x3,x1,x2
      cur = mk(0, 32'h10, 5'd1, 5'd2, 5'd3); #1;
      check_bit("t1_stall", stall_id, 1'b0);
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t1_add");

      // T2 load-use: lw x5 then add x6,x5,x1
      cur = mk(1, 32'h14, 5'd1, 5'd0, 5'd5); #1;
      check_bit("t2_lw_stall", stall_id, 1'b0);
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t2_lw");
      cur = mk(0, 32'h18, 5'd5, 5'd1, 5'd6); #1;
      check_bit("t2_haz_stall", stall_id, 1'b1);
      sb_q.push_back(bubble(1'b0));
      tick("t2_bubble");
      #1;
      check_bit("t2_retry_stall", stall_id, 1'b0);
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t2_add_retry");

      // T3 x0 destination never hazards
      cur = mk(1, 32'h1c, 5'd1, 5'd0, 5'd0); #1;
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t3_lw_x0");
      cur = mk(0, 32'h20, 5'd0, 5'd0, 5'd7); #1;
      check_bit("t3_x0_stall", stall_id, 1'b0);
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t3_add_x0");

      // T3 flush overrides a hazard
      cur = mk(1, 32'h24, 5'd1, 5'd0, 5'd5); #1;
      sb_q.push_back(as_load(cur, 1'b0));
      tick("t3_lw_x5");
      cur = mk(0, 32'h28, 5'd1, 5'd5, 5'd6); flush = 1'b1; #1;
      check_bit("t3_flush_stall", stall_id, 1'b0);
      sb_q.push_back(bubble(1'b0));
      tick("t3_flush_bubble");
      flush = 1'b0;

      // Invalid ID slot with control bits set loads a clean bubble
      cur = mk(1, 32'h2c, 5'd3, 5'd4, 5'd9); cur.valid = 1'b0; #1;
      sb_q.push_back(bubble(1'b0));
      tick("invalid_bubble");

      // T4 ext_stall beats flush, then flush alone
      cur = mk(0, 32'h40, 5'd1, 5'd2, 5'd8); #1;
      held = as_load(cur, 1'b0);
      sb_q.push_back(held);
      tick("t4_load_40");
      cur = mk(0, 32'h44, 5'd2, 5'd3, 5'd4); ext_stall = 1'b1; flush = 1'b1; #1;
      check_bit("t4_hold_stall", stall_id, 1'b1);
      sb_q.push_back(held);
      tick("t4_hold");
      ext_stall = 1'b0; #1;
      check_bit("t4_flush_stall", stall_id, 1'b0);
      sb_q.push_back(bubble(1'b0));
      tick("t4_flush_bubble");
      flush = 1'b0;

      // T5 halt is sticky and drains the pipe
      cur = mk(2, 32'h48, 5'd0, 5'd0, 5'd0); #1;
      check_bit("t5_pre_stall", stall_id, 1'b0);
      sb_q.push_back(as_load(cur, 1'b1));
      tick("t5_halt");
      cur = mk(0, 32'h4c, 5'd1, 5'd2, 5'd3); #1;
      check_bit("t5_halted_stall", stall_id, 1'b1);
      sb_q.push_back(bubble(1'b1));
      tick("t5_drain1");
      cur = mk(0, 32'h50, 5'd4, 5'd5, 5'd6); #1;
      sb_q.push_back(bubble(1'b1));
      tick("t5_drain2");

      // Asynchronous reset mid-operation clears everything immediately
      #2; rst_n = 1'b0; #1;
      check_ent("t5_async_reset", get_obs(), '0);
      check_bit("t5_reset_stall", stall_id, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      cur = mk(0, 32'h54, 5'd1, 5'd2, 5'd3); #1;
      sb_q.push_back(as_load(cur, 1'b0));
      tick("post_reset_load");

      checks++;
      assert (sb_q.size() == 0) else begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
